// File: rtl/change_dispenser_pkg.sv
// Shared vending definitions: refund FSM encoding, denominations and the greedy coin pick.
// Also imported by the coin-acceptance block.
package change_dispenser_pkg;

    localparam int unsigned AMT_W   = 5;
    localparam int unsigned STOCK_W = 4;

    localparam logic [AMT_W-1:0] DENOM_10 = 5'd10;
    localparam logic [AMT_W-1:0] DENOM_5  = 5'd5;
    localparam logic [AMT_W-1:0] DENOM_1  = 5'd1;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StIssue,
        StFinish,
        StFail
    } state_e;

    // Largest stocked denomination not exceeding amount; zero when nothing fits.
    function automatic logic [AMT_W-1:0] pick_denom(
        input logic [AMT_W-1:0] amount,
        input logic             has_10,
        input logic             has_5,
        input logic             has_1
    );
        if (amount >= DENOM_10 && has_10) begin
            return DENOM_10;
        end else if (amount >= DENOM_5 && has_5) begin
            return DENOM_5;
        end else if (amount >= DENOM_1 && has_1) begin
            return DENOM_1;
        end
        return '0;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_stock.sv
// Coin stock counters for the 10/5/1 tubes: parallel load, saturating decrement of the
// dispensed denomination, and per-tube availability flags.
module coin_stock
    import change_dispenser_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [STOCK_W-1:0] i_load_10,
    input  logic [STOCK_W-1:0] i_load_5,
    input  logic [STOCK_W-1:0] i_load_1,
    input  logic               i_dec,
    input  logic [AMT_W-1:0]   i_dec_value,
    output logic               o_has_10,
    output logic               o_has_5,
    output logic               o_has_1
);

    logic [STOCK_W-1:0] r_stock_10;
    logic [STOCK_W-1:0] r_stock_5;
    logic [STOCK_W-1:0] r_stock_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stock_10 <= '0;
            r_stock_5  <= '0;
            r_stock_1  <= '0;
        end else if (i_load) begin
            r_stock_10 <= i_load_10;
            r_stock_5  <= i_load_5;
            r_stock_1  <= i_load_1;
        end else if (i_dec) begin
            // Never wrap below zero even if asked to dispense from an empty tube.
            if (i_dec_value == DENOM_10 && r_stock_10 != '0) begin
                r_stock_10 <= r_stock_10 - STOCK_W'(1);
            end
            if (i_dec_value == DENOM_5 && r_stock_5 != '0) begin
                r_stock_5 <= r_stock_5 - STOCK_W'(1);
            end
            if (i_dec_value == DENOM_1 && r_stock_1 != '0) begin
                r_stock_1 <= r_stock_1 - STOCK_W'(1);
            end
        end
    end

    assign o_has_10 = (r_stock_10 != '0);
    assign o_has_5  = (r_stock_5 != '0);
    assign o_has_1  = (r_stock_1 != '0);

endmodule

// File: rtl/change_dispenser.sv
// Refund controller: pays out refund_amount greedily from the coin stock, one hopper
// handshake per coin, aborting on an empty stock or an unacknowledged coin.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AMT_W-1:0]   refund_amount,
    input  logic               stock_load,
    input  logic [STOCK_W-1:0] stock_10,
    input  logic [STOCK_W-1:0] stock_5,
    input  logic [STOCK_W-1:0] stock_1,
    input  logic               coin_ack,
    output logic               coin_out_valid,
    output logic [AMT_W-1:0]   coin_out_value,
    output logic               busy,
    output logic               refund_done,
    output logic               refund_err,
    output logic [AMT_W-1:0]   remaining
);

    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [AMT_W-1:0] r_remaining;
    logic [AMT_W-1:0] r_denom;
    logic [TmoW-1:0]  r_tmo;
    logic             r_err;

    logic             w_has_10;
    logic             w_has_5;
    logic             w_has_1;
    logic [AMT_W-1:0] w_pick;
    logic             w_ack;
    logic             w_tmo_expired;
    logic             w_load;

    assign w_pick        = pick_denom(r_remaining, w_has_10, w_has_5, w_has_1);
    assign w_ack         = coin_ack && (r_state == StIssue);
    assign w_tmo_expired = (r_tmo == TmoW'(ACK_TIMEOUT - 1));
    assign w_load        = stock_load && (r_state == StIdle);

    coin_stock u_stock (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_10   (stock_10),
        .i_load_5    (stock_5),
        .i_load_1    (stock_1),
        .i_dec       (w_ack),
        .i_dec_value (r_denom),
        .o_has_10    (w_has_10),
        .o_has_5     (w_has_5),
        .o_has_1     (w_has_1)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StSelect;
                end
            end
            StSelect: begin
                if (r_remaining == '0) begin
                    w_state_next = StFinish;
                end else if (w_pick != '0) begin
                    w_state_next = StIssue;
                end else begin
                    w_state_next = StFail;
                end
            end
            StIssue: begin
                if (w_ack) begin
                    w_state_next = StSelect;
                end else if (w_tmo_expired) begin
                    w_state_next = StFail;
                end
            end
            StFinish: w_state_next = StIdle;
            StFail:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_denom     <= '0;
            r_tmo       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && start) begin
                r_remaining <= refund_amount;
                r_err       <= 1'b0;
            end
            if (r_state == StSelect) begin
                r_denom <= w_pick;
                r_tmo   <= '0;
            end
            if (r_state == StIssue) begin
                if (w_ack) begin
                    r_remaining <= r_remaining - r_denom;
                end else if (!w_tmo_expired) begin
                    r_tmo <= r_tmo + TmoW'(1);
                end
            end
            // Raised on the way into FAIL so it accompanies the done pulse.
            if (w_state_next == StFail) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        coin_out_valid = (r_state == StIssue);
        coin_out_value = (r_state == StIssue) ? r_denom : '0;
        busy           = (r_state != StIdle);
        refund_done    = (r_state == StFinish) || (r_state == StFail);
        refund_err     = r_err;
        remaining      = r_remaining;
    end

endmodule
